// File: rtl/prog_loader_pkg.sv
// Shared MIPS loader parameters: loader state encoding and default word stride.
package prog_loader_pkg;

    localparam int unsigned ADDR_STEP_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/prog_loader_release_counter.sv
// Loadable saturating down-counter timing the processor reset release.
module release_counter #(
    parameter int unsigned width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             en,
    output logic             zero_c
);

    logic [width-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - width'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/prog_loader.sv
// Streams program words into instruction memory while holding the CPU in reset,
// then releases the CPU a fixed number of cycles after the final write.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned              mem_width      = 32,
    parameter int unsigned              mem_add_width  = 32,
    parameter int unsigned              mem_depth      = 256,
    parameter logic [mem_add_width-1:0] base_addr      = '0,
    parameter int unsigned              addr_step      = ADDR_STEP_DEFAULT,
    parameter int unsigned              release_cycles = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [mem_width-1:0]       in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       mem_we,
    output logic [mem_add_width-1:0]   mem_addr,
    output logic [mem_width-1:0]       mem_wdata,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(mem_depth):0] word_count
);

    localparam int unsigned cnt_w    = $clog2(mem_depth) + 1;
    localparam int unsigned rel_w    = (release_cycles > 1) ? $clog2(release_cycles) : 1;
    localparam int unsigned rel_init = (release_cycles > 0) ? (release_cycles - 1) : 0;

    ld_state_e state, state_next;

    logic                     xfer;
    logic                     session_start;
    logic                     rel_load;
    logic                     rel_zero_c;
    logic [mem_add_width-1:0] ptr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle strobes
    always_comb begin
        state_next    = state;
        xfer          = 1'b0;
        session_start = 1'b0;
        rel_load      = 1'b0;
        case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_next    = ST_LOAD;
                    session_start = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    xfer = 1'b1;
                    if (in_last) begin
                        state_next = ST_HOLD;
                        rel_load   = 1'b1;
                    end else if ((word_count + cnt_w'(1)) == cnt_w'(mem_depth)) begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_HOLD: begin
                if (rel_zero_c) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Loaded on the final transfer so it expires on the last HOLD cycle
    release_counter #(
        .width (rel_w)
    ) u_release_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (rel_load),
        .load_val (rel_w'(rel_init)),
        .en       (state == ST_HOLD),
        .zero_c   (rel_zero_c)
    );

    // Write port, address pointer and session bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= base_addr;
            mem_wdata  <= '0;
            ptr        <= base_addr;
            word_count <= '0;
        end else begin
            mem_we <= xfer;
            if (session_start) begin
                ptr        <= base_addr;
                word_count <= '0;
            end else if (xfer) begin
                mem_addr   <= ptr;
                mem_wdata  <= in_data;
                ptr        <= ptr + mem_add_width'(addr_step);
                word_count <= word_count + cnt_w'(1);
            end
        end
    end

    // Status outputs follow the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= (state_next == ST_LOAD);
            cpu_rst  <= (state_next != ST_RUN);
            busy     <= (state_next == ST_LOAD) || (state_next == ST_HOLD);
            done     <= (state_next == ST_RUN);
            err      <= (state_next == ST_ERR);
        end
    end

endmodule
